// File: rtl/ps2_key_decoder_if.sv
// Purpose: groups the PS/2 line inputs and the decoded key/byte outputs of ps2_key_decoder.
// Latency: none, wiring only.
// Backpressure: none; the PS/2 lines are input-only and every output is a level or one-cycle pulse.
// Ports: ps2_clk/ps2_data (raw keyboard lines), p1_*/p2_* held-key flags,
//        scan_code/scan_valid (last good byte + strobe), frame_err (bad/timed-out frame strobe).
interface ps2_key_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       p1_up;
    logic       p1_down;
    logic       p1_left;
    logic       p1_right;
    logic       p2_up;
    logic       p2_down;
    logic       p2_left;
    logic       p2_right;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    // Keyboard / stimulus side: drives the lines, observes the decoded outputs.
    modport master (
        output ps2_clk, ps2_data,
        input  p1_up, p1_down, p1_left, p1_right,
        input  p2_up, p2_down, p2_left, p2_right,
        input  scan_code, scan_valid, frame_err
    );

    // Decoder side: only reads the PS/2 lines, never drives them.
    modport slave (
        input  ps2_clk, ps2_data,
        output p1_up, p1_down, p1_left, p1_right,
        output p2_up, p2_down, p2_left, p2_right,
        output scan_code, scan_valid, frame_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// Purpose: PS/2 keyboard receiver; turns make/break scancodes into held W/S/A/D and arrow-key flags for two players.
// Latency: FILTER_LEN+4 clk from the raw stop-bit falling edge to scan_valid/frame_err/flag update.
// Backpressure: none; results are one-cycle pulses and held levels, the keyboard cannot be stalled.
// Ports: clk (100 MHz), rst (async, active-high), bus (ps2_key_decoder_if.slave: ps2 lines in, flags/scan_code/pulses out).
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic              clk,
    input  logic              rst,
    ps2_key_decoder_if.slave  bus
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYCLES - 1);

    // Synchronizers (idle level of both lines is 1).
    logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;

    // Glitch filter on the synchronized clock.
    logic           r_clk_f;
    logic [FCW-1:0] r_filt_cnt;
    logic           r_fall;

    // Frame receiver.
    logic [3:0]     r_bit_cnt;
    logic [9:0]     r_shift;
    logic [TCW-1:0] r_tmo_cnt;
    logic           r_rx_vld;
    logic           r_rx_err;
    logic [7:0]     r_rx_byte;
    logic           w_frame_ok;

    // Decoder / output registers.
    logic           r_ext;
    logic           r_brk;
    logic [7:0]     r_flags;   // {p2_right,p2_left,p2_down,p2_up,p1_right,p1_left,p1_down,p1_up}
    logic [7:0]     r_scan_code;
    logic           r_scan_vld;
    logic           r_frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= bus.ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= bus.ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // The filtered clock flips only after FILTER_LEN consecutive samples at the
    // opposite level; any sample back at the current level restarts the count.
    // r_fall is registered together with the flip so the receiver acts one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_f    <= 1'b1;
            r_filt_cnt <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_clk_s2 != r_clk_f) begin
                if (r_filt_cnt == FILT_LAST) begin
                    r_clk_f    <= r_clk_s2;
                    r_filt_cnt <= '0;
                    r_fall     <= ~r_clk_s2;
                end else begin
                    r_filt_cnt <= r_filt_cnt + FCW'(1);
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    // After ten shifts: [0]=start, [8:1]=data LSB first, [9]=parity; the
    // current sample is the stop bit.
    assign w_frame_ok = !r_shift[0] && (^r_shift[9:1]) && r_dat_s2;

    // A sampled edge always wins over the timeout, so a frame finishing on the
    // expiry cycle is still accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tmo_cnt <= '0;
            r_rx_vld  <= 1'b0;
            r_rx_err  <= 1'b0;
            r_rx_byte <= '0;
        end else begin
            r_rx_vld <= 1'b0;
            r_rx_err <= 1'b0;
            if (r_fall) begin
                r_tmo_cnt <= '0;
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt <= '0;
                    if (w_frame_ok) begin
                        r_rx_vld  <= 1'b1;
                        r_rx_byte <= r_shift[8:1];
                    end else begin
                        r_rx_err <= 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    r_shift   <= {r_dat_s2, r_shift[9:1]};
                end
            end else if (r_bit_cnt != 4'd0) begin
                if (r_tmo_cnt == TMO_LAST) begin
                    r_tmo_cnt <= '0;
                    r_bit_cnt <= '0;
                    r_rx_err  <= 1'b1;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + TCW'(1);
                end
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end

    // Prefix bytes only arm their flag; a key byte writes !break into its slot
    // (if mapped) and always consumes both prefixes. Bad frames drop prefixes
    // but leave held keys alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_flags     <= '0;
            r_scan_code <= '0;
            r_scan_vld  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_scan_vld  <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_rx_vld) begin
                r_scan_code <= r_rx_byte;
                r_scan_vld  <= 1'b1;
                if (r_rx_byte == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_rx_byte == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                    case ({r_ext, r_rx_byte})
                        9'h01D:  r_flags[0] <= ~r_brk;
                        9'h01B:  r_flags[1] <= ~r_brk;
                        9'h01C:  r_flags[2] <= ~r_brk;
                        9'h023:  r_flags[3] <= ~r_brk;
                        9'h175:  r_flags[4] <= ~r_brk;
                        9'h172:  r_flags[5] <= ~r_brk;
                        9'h16B:  r_flags[6] <= ~r_brk;
                        9'h174:  r_flags[7] <= ~r_brk;
                        default: ;
                    endcase
                end
            end else if (r_rx_err) begin
                r_frame_err <= 1'b1;
                r_ext       <= 1'b0;
                r_brk       <= 1'b0;
            end
        end
    end

    assign bus.p1_up      = r_flags[0];
    assign bus.p1_down    = r_flags[1];
    assign bus.p1_left    = r_flags[2];
    assign bus.p1_right   = r_flags[3];
    assign bus.p2_up      = r_flags[4];
    assign bus.p2_down    = r_flags[5];
    assign bus.p2_left    = r_flags[6];
    assign bus.p2_right   = r_flags[7];
    assign bus.scan_code  = r_scan_code;
    assign bus.scan_valid = r_scan_vld;
    assign bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Purpose: randomized scoreboard bench for ps2_key_decoder against a keyboard-level model.
// Latency: checks FILTER_LEN+4 clk from the stop-bit edge to every frame result.
// Backpressure: none; the bench drives the PS/2 lines like a keyboard.
module tb_ps2_key_decoder;

    localparam int FL  = 8;
    localparam int TMO = 1000;
    localparam int LAT = FL + 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ps2_key_decoder_if bus();

    ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         err;
        logic [7:0] code;
        logic [7:0] flags;
        int         stamp;   // negative: no latency check (timeout)
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Keyboard-level model: which keys are held and which prefixes are pending.
    bit         m_ext, m_brk;
    logic [7:0] m_flags;
    logic [7:0] key_codes[8] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74};
    logic [7:0] pool[10]     = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0};

    logic [7:0] w_flags;
    assign w_flags = {bus.p2_right, bus.p2_left, bus.p2_down, bus.p2_up,
                      bus.p1_right, bus.p1_left, bus.p1_down, bus.p1_up};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        m_flags = '0;
        sbq.delete();
    endfunction

    // Slots 0..3 are the plain W/S/A/D codes, 4..7 the extended arrows.
    function automatic void model_frame(input logic [7:0] b, input bit bad);
        exp_t e;
        e.err   = bad;
        e.code  = b;
        e.stamp = cyc;
        if (bad) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            for (int s = 0; s < 8; s++)
                if (key_codes[s] == b && (s >= 4) == m_ext)
                    m_flags[s] = !m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        e.flags = m_flags;
        sbq.push_back(e);
    endfunction

    function automatic void model_timeout();
        exp_t e;
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        e.err   = 1'b1;
        e.code  = 8'h00;
        e.flags = m_flags;
        e.stamp = -1;
        sbq.push_back(e);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the first nbits of a frame. bad flips the parity bit; glitch_bit
    // selects a bit during whose high phase ps2_clk is pulsed low for FL-1 cycles.
    task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits, input int glitch_bit);
        logic [10:0] bits;
        int          half;
        bits = {1'b1, (~^b) ^ bad, b, 1'b0};
        half = $urandom_range(2 * FL, 3 * FL);
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = bits[i];
            if (i == glitch_bit) begin
                idle(4);
                bus.ps2_clk = 1'b0;
                idle(FL - 1);
                bus.ps2_clk = 1'b1;
            end
            idle(half);
            bus.ps2_clk = 1'b0;
            if (i == 10) model_frame(b, bad);
            idle(half);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11, -1);
        idle($urandom_range(20, 60));
    endtask

    // Monitor: every result pulse pops one expected event; between pulses the
    // flags must sit at the last expected value.
    logic [7:0] exp_flags_now = '0;
    bit         prev_pulse    = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_pulse    = 1'b0;
            exp_flags_now = '0;
        end else if (bus.scan_valid || bus.frame_err) begin
            chk("pulse_width", {31'd0, prev_pulse}, 32'd0);
            chk("pulse_exclusive", {31'd0, bus.scan_valid & bus.frame_err}, 32'd0);
            if (sbq.size() == 0) begin
                chk("unexpected_event", {30'd0, bus.scan_valid, bus.frame_err}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("event_kind", {30'd0, bus.scan_valid, bus.frame_err}, e.err ? 32'd1 : 32'd2);
                if (!e.err) chk("scan_code", {24'd0, bus.scan_code}, {24'd0, e.code});
                chk("key_flags", {24'd0, w_flags}, {24'd0, e.flags});
                if (e.stamp >= 0) chk("latency", cyc - e.stamp, LAT);
                exp_flags_now = e.flags;
            end
            prev_pulse = 1'b1;
        end else begin
            chk("flags_steady", {24'd0, w_flags}, {24'd0, exp_flags_now});
            prev_pulse = 1'b0;
        end
    end

    initial begin
        logic [7:0] b;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst          = 1'b1;
        model_reset();
        idle(5);
        chk("reset_flags", {24'd0, w_flags}, 32'd0);
        chk("reset_scan_code", {24'd0, bus.scan_code}, 32'd0);
        chk("reset_pulses", {30'd0, bus.scan_valid, bus.frame_err}, 32'd0);
        rst = 1'b0;
        idle(5);

        // Player 1 make/break.
        send(8'h1D);
        chk("p1_up_make", {31'd0, bus.p1_up}, 32'd1);
        send(8'hF0);
        send(8'h1D);
        chk("p1_up_break", {31'd0, bus.p1_up}, 32'd0);

        // Player 2 extended keys; non-extended arrow code is ignored.
        send(8'hE0);
        send(8'h75);
        chk("p2_up_make", {24'd0, w_flags}, 32'h10);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk("p2_up_break", {31'd0, bus.p2_up}, 32'd0);
        send(8'h75);
        chk("plain_75_ignored", {24'd0, w_flags}, 32'd0);

        // Bad parity, then a good frame.
        send_frame(8'h1C, 1'b1, 11, -1);
        idle(40);
        chk("bad_parity_p1_left", {31'd0, bus.p1_left}, 32'd0);
        send(8'h1C);
        chk("p1_left_make", {31'd0, bus.p1_left}, 32'd1);

        // Timeout after 5 bits, then a clean frame must align.
        send_frame(8'h55, 1'b0, 5, -1);
        model_timeout();
        idle(TMO + 50);
        send(8'h23);
        chk("p1_right_after_timeout", {31'd0, bus.p1_right}, 32'd1);

        // Short ps2_clk glitch mid-frame must not create a bit.
        send_frame(8'h1B, 1'b0, 11, 4);
        idle(40);
        chk("glitch_scan_code", {24'd0, bus.scan_code}, 32'h1B);
        chk("glitch_p1_down", {31'd0, bus.p1_down}, 32'd1);

        // Randomized traffic over the interesting codes plus arbitrary bytes.
        for (int k = 0; k < 60; k++) begin
            int r;
            r = $urandom_range(0, 11);
            b = (r < 10) ? pool[r] : 8'($urandom);
            send_frame(b, $urandom_range(0, 9) == 0, 11, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 10) : -1);
            idle($urandom_range(20, 60));
        end

        // Hold W and Up, then reset in the middle of a frame.
        send(8'hF0);   // clear any leftover prefix state from random traffic
        send(8'h00);
        send(8'h1D);
        send(8'hE0);
        send(8'h75);
        chk("held_before_reset", {30'd0, bus.p2_up, bus.p1_up}, 32'd3);
        idle(50);
        chk("drained_before_reset", sbq.size(), 32'd0);
        send_frame(8'h23, 1'b0, 4, -1);
        rst = 1'b1;
        model_reset();
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        idle(5);
        chk("midframe_reset_flags", {24'd0, w_flags}, 32'd0);
        chk("midframe_reset_scan_code", {24'd0, bus.scan_code}, 32'd0);
        rst = 1'b0;
        idle(5);
        send(8'h1D);
        chk("p1_up_after_reset", {24'd0, w_flags}, 32'h01);

        idle(50);
        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
